wb_write_arbiter: RTL

//  Write-side driver for the register file's single write port (we/waddr/wdata).

---
 rtl/wb_write_arbiter_if.sv | 59 +++++
 rtl/wb_write_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for wb_write_arbiter: ALU/load result inputs, hazard check and register-file write port.
// Define WB_PERF_EN to add the perf_starve_cnt observation signal.
interface wb_write_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_waddr;
   logic [31:0] alu_wdata;

   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_waddr;
   logic [31:0] ld_wdata;

   logic [4:0]  chk_addr;
   logic        chk_hit;

   logic        stall_req;

   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;

`ifdef WB_PERF_EN
   logic [31:0] perf_starve_cnt;

   modport slave (
      input  alu_valid, alu_waddr, alu_wdata,
      input  ld_valid, ld_waddr, ld_wdata,
      input  chk_addr,
      output ld_ready, chk_hit, stall_req,
      output we, waddr, wdata,
      output perf_starve_cnt
   );

   modport master (
      output alu_valid, alu_waddr, alu_wdata,
      output ld_valid, ld_waddr, ld_wdata,
      output chk_addr,
      input  ld_ready, chk_hit, stall_req,
      input  we, waddr, wdata,
      input  perf_starve_cnt
   );
`else
   modport slave (
      input  alu_valid, alu_waddr, alu_wdata,
      input  ld_valid, ld_waddr, ld_wdata,
      input  chk_addr,
      output ld_ready, chk_hit, stall_req,
      output we, waddr, wdata
   );

   modport master (
      output alu_valid, alu_waddr, alu_wdata,
      output ld_valid, ld_waddr, ld_wdata,
      output chk_addr,
      input  ld_ready, chk_hit, stall_req,
      input  we, waddr, wdata
   );
`endif
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU results win, load results queue in an in-order FIFO.
// Define WB_PERF_EN to add a saturating count of stall_req cycles (perf_starve_cnt).
module wb_write_arbiter #(
   parameter int unsigned LD_DEPTH     = 4,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input logic               clk,
   input logic               rst,
   wb_write_arbiter_if.slave wb_if
);

   localparam int unsigned AW = $clog2(LD_DEPTH);
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_addr_q [LD_DEPTH];
   logic [31:0]   fifo_data_q [LD_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occupancy;
   logic [AW-1:0] chk_slot;

   logic          full, empty, push, pop;

   logic [CW-1:0] starve_q, starve_d;
   logic          stall_q, stall_d;

   logic          we_q, we_d;
   logic [4:0]    waddr_q, waddr_d;
   logic [31:0]   wdata_q, wdata_d;

   logic [4:0]    head_addr;
   logic [31:0]   head_data;
   logic          hit;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      occupancy = wr_ptr_q - rd_ptr_q;
      head_addr = fifo_addr_q[rd_ptr_q[AW-1:0]];
      head_data = fifo_data_q[rd_ptr_q[AW-1:0]];
   end

   always_comb begin
      push     = wb_if.ld_valid && !full && (wb_if.ld_waddr != '0);
      pop      = !wb_if.alu_valid && !empty;
      wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
   end

   // A non-empty FIFO that fails to pop is necessarily losing to the ALU.
   always_comb begin
      starve_d = starve_q;
      stall_d  = 1'b0;
      if (pop || empty) begin
         starve_d = '0;
      end else if (starve_q == CW'(STARVE_LIMIT - 1)) begin
         starve_d = '0;
         stall_d  = 1'b1;
      end else begin
         starve_d = starve_q + CW'(1);
      end
   end

   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (wb_if.alu_valid) begin
         we_d    = (wb_if.alu_waddr != '0);
         waddr_d = wb_if.alu_waddr;
         wdata_d = wb_if.alu_wdata;
      end else if (pop) begin
         we_d    = (head_addr != '0);
         waddr_d = head_addr;
         wdata_d = head_data;
      end
   end

   // Only live entries (between read and write pointers) count as hazards.
   always_comb begin
      hit      = 1'b0;
      chk_slot = '0;
      for (int unsigned k = 0; k < LD_DEPTH; k++) begin
         chk_slot = rd_ptr_q[AW-1:0] + AW'(k);
         if (((AW+1)'(k) < occupancy) && (fifo_addr_q[chk_slot] == wb_if.chk_addr)) begin
            hit = 1'b1;
         end
      end
      if (wb_if.chk_addr == '0) begin
         hit = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[AW-1:0]] <= wb_if.ld_waddr;
         fifo_data_q[wr_ptr_q[AW-1:0]] <= wb_if.ld_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wb_if.ld_ready  = !full;
   assign wb_if.chk_hit   = hit;
   assign wb_if.stall_req = stall_q;
   assign wb_if.we        = we_q;
   assign wb_if.waddr     = waddr_q;
   assign wb_if.wdata     = wdata_q;

`ifdef WB_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if (stall_q && (perf_q != '1)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign wb_if.perf_starve_cnt = perf_q;
`endif

endmodule
